// File: rtl/div_ctrl_pkg.sv
// Shared types for the divider sequencing controller: FSM state encoding and
// the {signed, op1, op2} key used by the optional result cache.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_DONE  = 2'd2,
    DIV_FLUSH = 2'd3
  } div_state_e;

  typedef struct packed {
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
  } div_key_t;

  function automatic div_key_t make_key(input logic sgn, input logic [31:0] op1,
                                        input logic [31:0] op2);
    div_key_t k;
    k.sgn = sgn;
    k.op1 = op1;
    k.op2 = op2;
    return k;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Controller <-> radix-2 divider connection. master = controller side,
// slave = divider side.
interface div_ctrl_if;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;

  modport master (
    output div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    output div_result_i, div_ready_i
  );
endinterface

// File: rtl/div_result_cache.sv
// One-entry divide result cache keyed on {signed, op1, op2}. Present only when
// DIV_CACHE_EN is defined; the entry is invalidated solely by reset.
`ifdef DIV_CACHE_EN
module div_result_cache
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  div_key_t    i_key,
  input  logic        i_fill,
  input  logic [63:0] i_fill_data,
  output logic        o_hit,
  output logic [63:0] o_data
);

  logic        r_vld;
  div_key_t    r_key;
  logic [63:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_key  <= '0;
      r_data <= '0;
    end else if (i_fill) begin
      r_vld  <= 1'b1;
      r_key  <= i_key;
      r_data <= i_fill_data;
    end
  end

  assign o_hit  = r_vld && (r_key == i_key);
  assign o_data = r_data;

endmodule
`endif

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU through the multi-cycle divider, stalls EX until
// the {rem, quot} result is ready and drains the divider on flush.
// Optional feature macro: DIV_CACHE_EN (one-entry result cache).
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_i,
  input  logic        signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        stallreq_o,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  div_ctrl_if.master  dif
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  div_state_e       r_state, w_next;
  logic [63:0]      r_result, w_result_d;
  logic [CNT_W-1:0] r_drain;
  logic             w_load_res, w_load_drain;
  logic             w_start, w_annul, w_stall;
  logic             w_hit;
  logic [63:0]      w_hit_data;

`ifdef DIV_CACHE_EN
  div_key_t w_key;
  logic     w_fill;

  assign w_key  = make_key(signed_i, op1_i, op2_i);
  // EX holds the operands stable while stalled, so the live inputs are the key.
  assign w_fill = (r_state == DIV_RUN) && !flush_i && dif.div_ready_i;

  div_result_cache u_cache (
    .clk         (clk),
    .rst         (rst),
    .i_key       (w_key),
    .i_fill      (w_fill),
    .i_fill_data (dif.div_result_i),
    .o_hit       (w_hit),
    .o_data      (w_hit_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_result <= '0;
      r_drain  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_res) r_result <= w_result_d;
      if (w_load_drain)          r_drain <= CNT_W'(DRAIN_CYCLES);
      else if (r_drain != '0)    r_drain <= r_drain - 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_annul      = 1'b0;
    w_stall      = 1'b0;
    w_load_res   = 1'b0;
    w_load_drain = 1'b0;
    w_result_d   = dif.div_result_i;
    case (r_state)
      DIV_IDLE: begin
        w_annul = flush_i;
        if (div_i && !flush_i) begin
          w_stall = 1'b1;
          if (w_hit) begin
            w_load_res = 1'b1;
            w_result_d = w_hit_data;
            w_next     = DIV_DONE;
          end else begin
            w_start = 1'b1;
            w_next  = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        w_stall = 1'b1;
        // Flush outranks a coincident ready: the result belongs to a dead instruction.
        if (flush_i) begin
          w_annul      = 1'b1;
          w_load_drain = 1'b1;
          w_next       = DIV_FLUSH;
        end else begin
          w_start = 1'b1;
          if (dif.div_ready_i) begin
            w_load_res = 1'b1;
            w_next     = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        if (!hold_i) w_next = DIV_IDLE;
      end
      DIV_FLUSH: begin
        w_annul = 1'b1;
        w_stall = div_i;
        if (r_drain == CNT_W'(1)) w_next = DIV_IDLE;
      end
      default: w_next = DIV_IDLE;
    endcase
  end

  assign stallreq_o       = w_stall;
  assign result_valid_o   = (r_state == DIV_DONE);
  assign result_o         = result_valid_o ? r_result : 64'h0;
  assign dif.div_start_o  = w_start;
  assign dif.div_annul_o  = w_annul;
  assign dif.div_signed_o = signed_i;
  assign dif.div_op1_o    = op1_i;
  assign dif.div_op2_o    = op2_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider, queue scoreboard with a decoupled
// monitor, directed cases plus randomized divides/flushes/holds.
module tb_div_ctrl;
  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_i = 1'b0, signed_i = 1'b0, flush_i = 1'b0, hold_i = 1'b0;
  logic [31:0] op1_i = '0, op2_i = '0;
  logic        stallreq_o, result_valid_o;
  logic [63:0] result_o;
  logic        inj_rdy = 1'b0;

  div_ctrl_if dif();

  div_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .div_i(div_i), .signed_i(signed_i),
    .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .hold_i(hold_i),
    .stallreq_o(stallreq_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .dif(dif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural DIV/DIVU: truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Divider model: ready in cycle 35 after a start in cycle 0 (cycle 3 for /0),
  // held until start drops; annul returns it to free.
  typedef enum logic [1:0] {DV_FREE, DV_BUSY, DV_END} dv_e;
  dv_e         dv_st;
  int          dv_cnt, dv_lat;
  logic [63:0] dv_res;

  always @(posedge clk) begin
    if (rst) dv_st <= DV_FREE;
    else case (dv_st)
      DV_FREE: if (dif.div_start_o && !dif.div_annul_o) begin
        dv_res <= ref_div(dif.div_signed_o, dif.div_op1_o, dif.div_op2_o);
        dv_lat <= (dif.div_op2_o == 32'h0) ? 3 : 35;
        dv_cnt <= 1;
        dv_st  <= DV_BUSY;
      end
      DV_BUSY: if (dif.div_annul_o) dv_st <= DV_FREE;
               else if (dv_cnt == dv_lat - 1) dv_st <= DV_END;
               else dv_cnt <= dv_cnt + 1;
      default: if (!dif.div_start_o) dv_st <= DV_FREE;
    endcase
  end

  assign dif.div_ready_i  = (dv_st == DV_END) || inj_rdy;
  assign dif.div_result_i = (dv_st == DV_END) ? dv_res : (inj_rdy ? 64'hDEAD_BEEF_0BAD_F00D : 64'h0);

  // One-entry cache reference (only consulted when the feature is built in).
  logic        cm_vld = 1'b0;
  logic [64:0] cm_key;
  logic [63:0] cm_dat;

  function automatic logic cache_hit(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_CACHE_EN
    return cm_vld && (cm_key == {s, a, b});
`else
    return 1'b0;
`endif
  endfunction

  typedef struct { logic [63:0] res; int vcyc; } exp_t;
  exp_t sb[$];
  bit   mon_first = 1'b1;

  // Monitor: every DONE cycle is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid_o) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_valid: result_valid_o=1 result=%h, none expected (cycle %0d)", result_o, cyc);
        end else begin
          chk("result", result_o, sb[0].res);
          if (mon_first) chk("valid_cycle", 64'(cyc), 64'(sb[0].vcyc));
          chk("stall_in_done", 64'(stallreq_o), 64'h0);
          mon_first = 1'b0;
          if (!hold_i) begin
            void'(sb.pop_front());
            mon_first = 1'b1;
          end
        end
      end else begin
        chk("result_idle_zero", result_o, 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one surviving divide. pre = cycles it waits in FLUSH before IDLE.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input int hold_n, input int pre);
    logic hit;
    int   lat, stalls, starts, guard;
    bit   seen;
    hit    = cache_hit(s, a, b);
    lat    = hit ? 1 : ((b == 32'h0) ? 4 : 36);
    stalls = 0; starts = 0; guard = 0; seen = 1'b0;
    sb.push_back('{ref_div(s, a, b), cyc + pre + lat});
    if (!hit) begin cm_vld = 1'b1; cm_key = {s, a, b}; cm_dat = ref_div(s, a, b); end
    div_i = 1'b1; signed_i = s; op1_i = a; op2_i = b; hold_i = (hold_n > 0);
    while (!seen && guard < 300) begin
      @(negedge clk);
      if (result_valid_o) seen = 1'b1;
      else begin
        stalls += int'(stallreq_o);
        starts += int'(dif.div_start_o);
        guard++;
      end
    end
    if (!seen) begin
      checks++; errs++;
      $display("FAIL timeout: no result_valid_o for op %h/%h after %0d cycles", a, b, guard);
    end
    chk("stall_cycles", 64'(stalls), 64'(pre + lat));
    chk("start_cycles", 64'(starts), hit ? 64'h0 : 64'(lat));
    for (int k = 1; k <= hold_n; k++) begin
      tick();
      if (k == hold_n) hold_i = 1'b0;
    end
    tick();
    div_i = 1'b0; hold_i = 1'b0;
  endtask

  // Start a divide, flush it k cycles later, then drain (or re-issue a2/b2 in FLUSH).
  task automatic flush_run(input logic s, input logic [31:0] a, input logic [31:0] b, input int k,
                           input bit reissue, input logic [31:0] a2, input logic [31:0] b2);
    if (cache_hit(s, a, b)) begin
      issue(s, a, b, 0, 0);
      return;
    end
    div_i = 1'b1; signed_i = s; op1_i = a; op2_i = b; hold_i = 1'b0;
    repeat (k) tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_annul", 64'(dif.div_annul_o), 64'h1);
    chk("flush_nostart", 64'(dif.div_start_o), 64'h0);
    tick();
    flush_i = 1'b0; div_i = 1'b0;
    if (reissue) begin
      issue(1'b0, a2, b2, 0, DRAIN);
    end else begin
      inj_rdy = 1'b1;
      for (int i = 0; i < DRAIN; i++) begin
        @(negedge clk);
        chk("drain_annul", 64'(dif.div_annul_o), 64'h1);
        chk("drain_nostart", 64'(dif.div_start_o), 64'h0);
        chk("drain_nostall", 64'(stallreq_o), 64'h0);
        tick();
        inj_rdy = 1'b0;
      end
      @(negedge clk);
      chk("post_drain_annul", 64'(dif.div_annul_o), 64'h0);
      tick();
    end
  endtask

  task automatic gen(input logic s, output logic [31:0] a, output logic [31:0] b);
    int sel;
    sel = int'($urandom_range(0, 3));
    a   = $urandom;
    case (sel)
      0:       b = 32'h0;
      1:       b = 32'($urandom_range(1, 15));
      default: b = $urandom;
    endcase
    if (b == 32'h0 && sel != 0) b = 32'h3;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic        s;
    logic [31:0] a, b, a2, b2;
    int          mode, rl, kf;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(stallreq_o), 64'h0);
    chk("rst_valid", 64'(result_valid_o), 64'h0);
    chk("rst_start", 64'(dif.div_start_o), 64'h0);
    chk("rst_annul", 64'(dif.div_annul_o), 64'h0);
    chk("rst_result", result_o, 64'h0);
    tick();

    // Request killed in the same cycle: no start, annul follows flush.
    div_i = 1'b1; flush_i = 1'b1; op1_i = 32'd8; op2_i = 32'd2;
    @(negedge clk);
    chk("idle_flush_nostart", 64'(dif.div_start_o), 64'h0);
    chk("idle_flush_nostall", 64'(stallreq_o), 64'h0);
    chk("idle_flush_annul", 64'(dif.div_annul_o), 64'h1);
    tick();
    div_i = 1'b0; flush_i = 1'b0;
    tick();

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    issue(1'b0, 32'd100, 32'd7, 0, 0);
    issue(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 0);
    issue(1'b1, 32'd5, 32'd0, 0, 0);
    flush_run(1'b0, 32'd1000, 32'd3, 10, 1'b0, 32'd0, 32'd0);
    issue(1'b0, 32'd9, 32'd3, 0, 0);
    flush_run(1'b1, 32'hFFFF_FFCE, 32'd7, 35, 1'b1, 32'd9, 32'd3);
    issue(1'b0, 32'd77, 32'd5, 3, 0);
    issue(1'b0, 32'd100, 32'd7, 0, 0);

    // Reset mid-RUN: back to IDLE in one cycle, cache forgotten.
    div_i = 1'b1; signed_i = 1'b0; op1_i = 32'd100; op2_i = 32'd7;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; div_i = 1'b0; cm_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(stallreq_o), 64'h0);
    chk("post_rst_start", 64'(dif.div_start_o), 64'h0);
    chk("post_rst_valid", 64'(result_valid_o), 64'h0);
    tick();
    issue(1'b0, 32'd100, 32'd7, 0, 0);

    for (int n = 0; n < 16; n++) begin
      s    = 1'($urandom_range(0, 1));
      gen(s, a, b);
      mode = int'($urandom_range(0, 4));
      if (mode == 0) begin
        rl = (b == 32'h0) ? 4 : 36;
        kf = int'($urandom_range(1, rl - 1));
        gen(1'b0, a2, b2);
        flush_run(s, a, b, kf, 1'($urandom_range(0, 1)), a2, b2);
      end else begin
        issue(s, a, b, int'($urandom_range(0, 2)), 0);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the execute stage and the multi-cycle radix-2 divider. It accepts DIV/DIVU requests from EX and drives the divider's start/annul/sign/operand inputs. It stalls the pipeline until the 64-bit {remainder, quotient} result is ready, then presents that result to the HI/LO write path. It also handles flushes, including draining a divider that is mid-operation so the divider is idle before the next request.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles spent in FLUSH with start low and annul high. Must be ≥2 to cover the divider's divide-by-zero path.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `div_i` in 1: EX holds a divide instruction; held stable while `stallreq_o`=1.
- `signed_i` in 1: 1 = DIV, 0 = DIVU.
- `op1_i` in 32: dividend.
- `op2_i` in 32: divisor.
- `flush_i` in 1: EX instruction is killed this cycle.
- `hold_i` in 1: EX is stalled by a downstream stage and cannot retire this cycle.
- `stallreq_o` out 1: request pipeline stall for the division.
- `result_o` out 64: {hi = remainder, lo = quotient}. Valid when `result_valid_o`=1, zero otherwise.
- `result_valid_o` out 1: result available to the HI/LO write path.
- `div_start_o` out 1: to divider `start_i`.
- `div_annul_o` out 1: to divider `annul_i`.
- `div_signed_o` out 1: to divider `signed_div_i`.
- `div_op1_o` out 32: to divider `opdata1_i`.
- `div_op2_o` out 32: to divider `opdata2_i`.
- `div_result_i` in 64: from divider `result_o`.
- `div_ready_i` in 1: from divider `ready_o`.

## Operation
- States: IDLE, RUN, DONE, FLUSH. A 2-bit encoding, default IDLE.
- Operands and sign are passed straight through from `op1_i`, `op2_i` and `signed_i`.
- IDLE:
  - `div_i`=1 and `flush_i`=0: `div_start_o`=1 and `stallreq_o`=1 combinationally. Next state is RUN.
  - `div_i`=1 and `flush_i`=1: no start; stay in IDLE.
- RUN:
  - `div_start_o`=1 and `stallreq_o`=1.
  - `flush_i`=1: `div_annul_o`=1, `div_start_o`=0. Load the drain counter with `DRAIN_CYCLES`. Next state is FLUSH. Flush has priority over `div_ready_i`.
  - Else if `div_ready_i`=1: register `div_result_i` into the result register. Next state is DONE.
- DONE:
  - `div_start_o`=0, which returns the divider to free.
  - `result_valid_o`=1, `stallreq_o`=0.
  - `hold_i`=1: stay in DONE; result held stable.
  - `flush_i`=1: go to IDLE and discard the result.
  - Else go to IDLE.
- FLUSH:
  - `div_annul_o`=1, `div_start_o`=0, `stallreq_o`=0.
  - Counter decrements each cycle; at 1, next state is IDLE.
  - `div_ready_i` pulses in FLUSH are ignored.
  - A `div_i` arriving during FLUSH waits: `stallreq_o`=1 if `div_i`=1.
- `div_annul_o` = `flush_i` in IDLE/RUN; forced to 1 in FLUSH.
- Divide by zero needs no special handling. The divider returns its defined by-zero result ({hi=0, lo=0}) and the controller passes it through.

## Timing
- Reset values: state IDLE; result register 0. `stallreq_o`, `result_valid_o`, `div_start_o` and `div_annul_o` are 0; `result_o` is 0.
- Normal division, with request in cycle 0:
  - `div_ready_i` is seen in cycle 35.
  - DONE in cycle 36: `stallreq_o` is high for cycles 0–35; `result_valid_o` is high in cycle 36.
  - Total latency is 37 cycles to retire.
- Divisor zero: `div_ready_i` arrives in cycle 3; DONE in cycle 4.
- Back-to-back divides: after DONE comes IDLE, and the next start is in the cycle after DONE. There is no bubble beyond the IDLE cycle.
- Reset mid-RUN: the controller returns to IDLE in one cycle. The divider is reset by the same `rst`.

## Configuration
- `DIV_CACHE_EN`: a one-entry result cache keyed on {signed, op1, op2}, with a valid bit.
  - Filled on every RUN→DONE transition. Not filled on flushed operations. Cleared only by reset.
  - IDLE request that hits: no start; next state is DONE with the cached result. `stallreq_o` is high for the request cycle only, giving 2-cycle latency.
  - Without the macro: the cache logic is absent, and every request takes the IDLE→RUN path.

## Structure
- State encodings (`DivCtrlIdle/Run/Done/Flush`) and the drain width go into `defines.vh` next to the existing divider state constants.
- Optional sub-module `div_result_cache`: inputs are key, fill strobe and fill data; outputs are hit and data. It is instantiated only under `DIV_CACHE_EN`.

## Test plan
- Signed: DIV of 0xFFFFFFF9 (−7) by 2 → stall cycles 0–35, `result_valid_o` in cycle 36, `result_o`=0xFFFFFFFF_FFFFFFFD.
- DIVU of 100 by 7, immediately followed by DIVU of 0xFFFFFFFF by 0x10 → first result 0x00000002_0000000E. Second start in the cycle after DONE; result 0x0000000F_0FFFFFFF.
- Divisor zero: DIV of 5 by 0 → DONE in cycle 4, `result_o`=0.
- Flush during RUN at cycle 10:
  - FLUSH for 2 cycles with `div_annul_o`=1, then IDLE.
  - A new DIVU of 9 by 3 gives 0x00000000_00000003 with normal latency.
- `hold_i` high for 3 cycles in DONE → `result_valid_o` and `result_o` stable for 4 cycles, then IDLE.
- With `DIV_CACHE_EN`, repeat DIVU of 100 by 7 → no `div_start_o`, `result_valid_o` in cycle 1. A reset in between forces the full 37-cycle path.
